// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory port arbiter: FSM states, owner
// identity, default parameter values and the debug view of the FSM.
package mem_arb_pkg;

   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_TIMEOUT    = 64;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_GNT    = 2'd1,
      WAIT_RVALID = 2'd2
   } arb_state_e;

   typedef enum logic {
      INSTR = 1'b0,
      DATA  = 1'b1
   } owner_e;

   typedef struct packed {
      arb_state_e state;
      owner_e     owner;
      owner_e     last_owner;
   } arb_dbg_t;

   function automatic owner_e other_owner(input owner_e o);
      return (o == INSTR) ? DATA : INSTR;
   endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Round-robin winner between the fetch and load/store masters.
// A lone requester always wins; on contention the master not granted last wins.
module mem_arb_rr_pick
   import mem_arb_pkg::*;
(
   input  logic   instr_req_i,
   input  logic   data_req_i,
   input  owner_e last_owner_i,
   output owner_e winner_o
);

   always_comb begin
      winner_o = INSTR;
      if (instr_req_i && data_req_i) begin
         winner_o = other_owner(last_owner_i);
      end else if (data_req_i) begin
         winner_o = DATA;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between a fetch master and a
// load/store master, one transaction in flight, with a response timeout.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    instr_req_i,
   input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
   output logic                    instr_gnt_o,
   output logic                    instr_rvalid_o,
   output logic [DATA_WIDTH-1:0]   instr_rdata_o,

   input  logic                    data_req_i,
   input  logic                    data_we_i,
   input  logic [DATA_WIDTH/8-1:0] data_be_i,
   input  logic [ADDR_WIDTH-1:0]   data_addr_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   output logic                    data_gnt_o,
   output logic                    data_rvalid_o,
   output logic [DATA_WIDTH-1:0]   data_rdata_o,

   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic                    mem_gnt_i,
   input  logic                    mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,

   output logic                    timeout_o
);

   localparam int                   CNT_WIDTH = $clog2(TIMEOUT + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(TIMEOUT - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   arb_state_e             state_q, state_d;
   owner_e                 owner_q, owner_d;
   owner_e                 last_owner_q, last_owner_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

   owner_e                 pick;
   logic                   in_wait_gnt;
   logic                   in_wait_rvalid;
   logic                   owner_is_data;
   logic                   timeout_hit;
   arb_dbg_t               dbg;

   mem_arb_rr_pick u_pick (
      .instr_req_i  (instr_req_i),
      .data_req_i   (data_req_i),
      .last_owner_i (last_owner_q),
      .winner_o     (pick)
   );

   assign in_wait_gnt    = (state_q == WAIT_GNT);
   assign in_wait_rvalid = (state_q == WAIT_RVALID);
   assign owner_is_data  = (owner_q == DATA);

   // The TIMEOUT-th response cycle expires unless the response shows up in it.
   assign timeout_hit = in_wait_rvalid && (cnt_q == CNT_LAST) && !mem_rvalid_i;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      cnt_d        = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (instr_req_i || data_req_i) begin
               state_d = WAIT_GNT;
               owner_d = pick;
            end
         end
         WAIT_GNT: begin
            if (mem_gnt_i) begin
               state_d      = WAIT_RVALID;
               last_owner_d = owner_q;
               cnt_d        = '0;
            end
         end
         WAIT_RVALID: begin
            if (mem_rvalid_i || timeout_hit) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= INSTR;
         last_owner_q <= DATA;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
      end
   end

   // Memory side follows the owner's live inputs; fetches are full-word reads.
   assign mem_req_o   = in_wait_gnt;
   assign mem_addr_o  = owner_is_data ? data_addr_i  : instr_addr_i;
   assign mem_we_o    = owner_is_data ? data_we_i    : 1'b0;
   assign mem_be_o    = owner_is_data ? data_be_i    : '1;
   assign mem_wdata_o = owner_is_data ? data_wdata_i : '0;

   assign instr_gnt_o    = mem_gnt_i    && in_wait_gnt    && !owner_is_data;
   assign data_gnt_o     = mem_gnt_i    && in_wait_gnt    &&  owner_is_data;
   assign instr_rvalid_o = mem_rvalid_i && in_wait_rvalid && !owner_is_data;
   assign data_rvalid_o  = mem_rvalid_i && in_wait_rvalid &&  owner_is_data;
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;
   assign timeout_o      = timeout_hit;

   assign dbg = '{state: state_q, owner: owner_q, last_owner: last_owner_q};

   a_gnt_exclusive: assert property (@(posedge clk) disable iff (rst)
      !(instr_gnt_o && data_gnt_o));
   a_rvalid_exclusive: assert property (@(posedge clk) disable iff (rst)
      !(instr_rvalid_o && data_rvalid_o));
   a_state_legal: assert property (@(posedge clk) disable iff (rst)
      dbg.state inside {IDLE, WAIT_GNT, WAIT_RVALID});
   a_owner_held: assert property (@(posedge clk) disable iff (rst)
      (dbg.state != IDLE) |-> (owner_d == dbg.owner));
   a_last_is_owner: assert property (@(posedge clk) disable iff (rst)
      (dbg.state == WAIT_RVALID) |-> (dbg.last_owner == dbg.owner));
   a_cnt_range: assert property (@(posedge clk) disable iff (rst)
      cnt_q <= CNT_LAST);
   a_rvalid_beats_timeout: assert property (@(posedge clk) disable iff (rst)
      timeout_o |-> !mem_rvalid_i);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written timeout and
// reset sequences, then random traffic against a transaction-level model.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW  = DEF_ADDR_WIDTH;
   localparam int DW  = DEF_DATA_WIDTH;
   localparam int BW  = DW / 8;
   localparam int TMO = DEF_TIMEOUT;

   logic          clk;
   logic          rst;
   logic          instr_req_i;
   logic [AW-1:0] instr_addr_i;
   logic          instr_gnt_o;
   logic          instr_rvalid_o;
   logic [DW-1:0] instr_rdata_o;
   logic          data_req_i;
   logic          data_we_i;
   logic [BW-1:0] data_be_i;
   logic [AW-1:0] data_addr_i;
   logic [DW-1:0] data_wdata_i;
   logic          data_gnt_o;
   logic          data_rvalid_o;
   logic [DW-1:0] data_rdata_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [BW-1:0] mem_be_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_gnt_i;
   logic          mem_rvalid_i;
   logic [DW-1:0] mem_rdata_i;
   logic          timeout_o;

   mem_port_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .instr_req_i    (instr_req_i),
      .instr_addr_i   (instr_addr_i),
      .instr_gnt_o    (instr_gnt_o),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_rdata_o  (instr_rdata_o),
      .data_req_i     (data_req_i),
      .data_we_i      (data_we_i),
      .data_be_i      (data_be_i),
      .data_addr_i    (data_addr_i),
      .data_wdata_i   (data_wdata_i),
      .data_gnt_o     (data_gnt_o),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .mem_be_o       (mem_be_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_gnt_i      (mem_gnt_i),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i),
      .timeout_o      (timeout_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- transaction-level reference ----------------
   // One transaction at a time: it is opened when a master asks while nothing
   // is open, gets accepted by the memory grant, and closes on a response or
   // after TMO response cycles.  Who: 0 = fetch, 1 = load/store.
   bit m_open     = 1'b0;
   bit m_accepted = 1'b0;
   int m_who      = 0;
   int m_prev     = 1;
   int m_age      = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_open     <= 1'b0;
         m_accepted <= 1'b0;
         m_prev     <= 1;
         m_age      <= 0;
      end else if (!m_open) begin
         if (instr_req_i || data_req_i) begin
            m_open     <= 1'b1;
            m_accepted <= 1'b0;
            if (instr_req_i && data_req_i) m_who <= 1 - m_prev;
            else                           m_who <= data_req_i ? 1 : 0;
         end
      end else if (!m_accepted) begin
         if (mem_gnt_i) begin
            m_accepted <= 1'b1;
            m_prev     <= m_who;
            m_age      <= 0;
         end
      end else if (mem_rvalid_i || (m_age == TMO - 1)) begin
         m_open <= 1'b0;
      end else begin
         m_age <= m_age + 1;
      end
   end

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [5:0] ctrl_now();
      return {instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o, mem_req_o, timeout_o};
   endfunction

   task automatic model_check(input string tag);
      logic e_mreq, e_fly;
      logic [5:0] e;
      e_mreq = m_open && !m_accepted;
      e_fly  = m_open && m_accepted;
      e = {e_mreq && mem_gnt_i && (m_who == 0),
           e_fly && mem_rvalid_i && (m_who == 0),
           e_mreq && mem_gnt_i && (m_who == 1),
           e_fly && mem_rvalid_i && (m_who == 1),
           e_mreq,
           e_fly && !mem_rvalid_i && (m_age == TMO - 1)};
      chk({tag, ".ctrl"}, 64'(ctrl_now()), 64'(e));
      chk({tag, ".irdata"}, 64'(instr_rdata_o), 64'(mem_rdata_i));
      chk({tag, ".drdata"}, 64'(data_rdata_o), 64'(mem_rdata_i));
      if (e_mreq) begin
         if (m_who == 1) begin
            chk({tag, ".addr"}, 64'(mem_addr_o), 64'(data_addr_i));
            chk({tag, ".we"}, 64'(mem_we_o), 64'(data_we_i));
            chk({tag, ".be"}, 64'(mem_be_o), 64'(data_be_i));
            if (data_we_i) chk({tag, ".wdata"}, 64'(mem_wdata_o), 64'(data_wdata_i));
         end else begin
            chk({tag, ".addr"}, 64'(mem_addr_o), 64'(instr_addr_i));
            chk({tag, ".we"}, 64'(mem_we_o), 64'd0);
            chk({tag, ".be"}, 64'(mem_be_o), 64'({BW{1'b1}}));
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic r, input logic ir, input logic [AW-1:0] ia,
                         input logic dr, input logic dw, input logic [BW-1:0] db,
                         input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                         input logic g, input logic rv, input logic [DW-1:0] rd);
      rst          = r;
      instr_req_i  = ir;
      instr_addr_i = ia;
      data_req_i   = dr;
      data_we_i    = dw;
      data_be_i    = db;
      data_addr_i  = da;
      data_wdata_i = dwd;
      mem_gnt_i    = g;
      mem_rvalid_i = rv;
      mem_rdata_i  = rd;
   endtask

   task automatic idle_in(input logic [DW-1:0] rd);
      set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, rd);
   endtask

   // ---------------- vector table ----------------
   // e_ctrl bits: {instr_gnt, instr_rvalid, data_gnt, data_rvalid, mem_req, timeout}
   typedef struct {
      logic          rst;
      logic          ireq;
      logic [7:0]    iaddr;
      logic          dreq;
      logic          dwe;
      logic [3:0]    dbe;
      logic [7:0]    daddr;
      logic [31:0]   dwdata;
      logic          gnt;
      logic          rv;
      logic [31:0]   rdata;
      logic [5:0]    e_ctrl;
      logic          e_we;
      logic [3:0]    e_be;
      logic [7:0]    e_addr;
      logic [31:0]   e_wdata;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic ir, logic [7:0] ia, logic dr, logic dw,
                               logic [3:0] db, logic [7:0] da, logic [31:0] dwd,
                               logic g, logic rv, logic [31:0] rd, logic [5:0] ec,
                               logic ew, logic [3:0] eb, logic [7:0] ea, logic [31:0] ewd);
      vec_t v;
      v = '{rst: r, ireq: ir, iaddr: ia, dreq: dr, dwe: dw, dbe: db, daddr: da,
            dwdata: dwd, gnt: g, rv: rv, rdata: rd, e_ctrl: ec, e_we: ew,
            e_be: eb, e_addr: ea, e_wdata: ewd};
      return v;
   endfunction

   localparam logic [5:0] C_NONE = 6'b000000;
   localparam logic [5:0] C_REQ  = 6'b000010;
   localparam logic [5:0] C_IGNT = 6'b100010;
   localparam logic [5:0] C_DGNT = 6'b001010;
   localparam logic [5:0] C_IRV  = 6'b010000;
   localparam logic [5:0] C_DRV  = 6'b000100;

   task automatic fill_table();
      // fetch from 0x04: grant one cycle late, response one cycle late, then stray responses
      vecs.push_back(mk(0,1,8'h04,0,0,4'h0,8'h00,32'h0, 0,0,32'h0,         C_NONE,0,4'h0,8'h00,32'h0));
      vecs.push_back(mk(0,1,8'h04,0,0,4'h0,8'h00,32'h0, 0,0,32'h0,         C_REQ, 0,4'hF,8'h04,32'h0));
      vecs.push_back(mk(0,1,8'h04,0,0,4'h0,8'h00,32'h0, 1,0,32'h0,         C_IGNT,0,4'hF,8'h04,32'h0));
      vecs.push_back(mk(0,0,8'h00,0,0,4'h0,8'h00,32'h0, 0,0,32'h0,         C_NONE,0,4'h0,8'h00,32'h0));
      vecs.push_back(mk(0,0,8'h00,0,0,4'h0,8'h00,32'h0, 0,1,32'h1234_5678, C_IRV, 0,4'h0,8'h00,32'h0));
      vecs.push_back(mk(0,0,8'h00,0,0,4'h0,8'h00,32'h0, 0,1,32'hAAAA_5555, C_NONE,0,4'h0,8'h00,32'h0));
      vecs.push_back(mk(0,0,8'h00,0,0,4'h0,8'h00,32'h0, 0,1,32'h0F0F_0F0F, C_NONE,0,4'h0,8'h00,32'h0));
      // store 0xDEADBEEF to 0x70
      vecs.push_back(mk(0,0,8'h00,1,1,4'hF,8'h70,32'hDEAD_BEEF, 0,0,32'h0, C_NONE,0,4'h0,8'h00,32'h0));
      vecs.push_back(mk(0,0,8'h00,1,1,4'hF,8'h70,32'hDEAD_BEEF, 1,0,32'h0, C_DGNT,1,4'hF,8'h70,32'hDEAD_BEEF));
      vecs.push_back(mk(0,0,8'h00,0,1,4'hF,8'h70,32'hDEAD_BEEF, 0,0,32'h0, C_NONE,0,4'h0,8'h00,32'h0));
      vecs.push_back(mk(0,0,8'h00,0,0,4'h0,8'h00,32'h0, 0,1,32'h0000_0001, C_DRV, 0,4'h0,8'h00,32'h0));
      vecs.push_back(mk(0,0,8'h00,0,0,4'h0,8'h00,32'h0, 0,0,32'h0,         C_NONE,0,4'h0,8'h00,32'h0));
      // reset, then both masters asking every cycle: instr, data, instr, data
      vecs.push_back(mk(1,1,8'h10,1,0,4'h3,8'h20,32'h0, 0,0,32'h0, C_NONE,0,4'h0,8'h00,32'h0));
      for (int k = 0; k < 4; k++) begin
         vecs.push_back(mk(0,1,8'h10,1,0,4'h3,8'h20,32'h0, 0,0,32'h0, C_NONE,0,4'h0,8'h00,32'h0));
         if (k % 2 == 0) begin
            vecs.push_back(mk(0,1,8'h10,1,0,4'h3,8'h20,32'h0, 1,0,32'h0,   C_IGNT,0,4'hF,8'h10,32'h0));
            vecs.push_back(mk(0,1,8'h10,1,0,4'h3,8'h20,32'h0, 0,1,32'h55+k,C_IRV, 0,4'h0,8'h00,32'h0));
         end else begin
            vecs.push_back(mk(0,1,8'h10,1,0,4'h3,8'h20,32'h0, 1,0,32'h0,   C_DGNT,0,4'h3,8'h20,32'h0));
            vecs.push_back(mk(0,1,8'h10,1,0,4'h3,8'h20,32'h0, 0,1,32'h66+k,C_DRV, 0,4'h0,8'h00,32'h0));
         end
      end
      vecs.push_back(mk(0,0,8'h00,0,0,4'h0,8'h00,32'h0, 0,0,32'h0, C_NONE,0,4'h0,8'h00,32'h0));
      // fetch request dropped while waiting for grant still completes
      vecs.push_back(mk(0,1,8'h44,0,0,4'h0,8'h00,32'h0, 0,0,32'h0, C_NONE,0,4'h0,8'h00,32'h0));
      vecs.push_back(mk(0,0,8'h44,0,0,4'h0,8'h00,32'h0, 0,0,32'h0, C_REQ, 0,4'hF,8'h44,32'h0));
      vecs.push_back(mk(0,0,8'h44,0,0,4'h0,8'h00,32'h0, 0,0,32'h0, C_REQ, 0,4'hF,8'h44,32'h0));
      vecs.push_back(mk(0,0,8'h44,0,0,4'h0,8'h00,32'h0, 1,0,32'h0, C_IGNT,0,4'hF,8'h44,32'h0));
      vecs.push_back(mk(0,0,8'h00,0,0,4'h0,8'h00,32'h0, 0,1,32'h7, C_IRV, 0,4'h0,8'h00,32'h0));
      vecs.push_back(mk(0,0,8'h00,0,0,4'h0,8'h00,32'h0, 0,0,32'h0, C_NONE,0,4'h0,8'h00,32'h0));
   endtask

   // ---------------- hand-written multi-cycle sequences ----------------
   task automatic seq_timeout(input bit tie);
      int  first_tmo;
      int  n_tmo;
      bit  rv_early;
      string tag;
      tag = tie ? "tie" : "tmo";
      tick(); set_in(0,0,'0,1,0,'1,8'h30,'0,0,0,'0); @(negedge clk); model_check({tag, "_req"});
      tick(); set_in(0,0,'0,1,0,'1,8'h30,'0,1,0,'0); @(negedge clk); model_check({tag, "_gnt"});
      chk({tag, "_data_gnt"}, 64'(data_gnt_o), 64'd1);
      first_tmo = 0;
      n_tmo     = 0;
      rv_early  = 1'b0;
      for (int n = 1; n <= TMO + 4 && first_tmo == 0 && !(tie && n > TMO); n++) begin
         tick();
         idle_in(DW'($urandom));
         if (tie && n == TMO) mem_rvalid_i = 1'b1;
         @(negedge clk);
         model_check({tag, "_wait"});
         if (timeout_o) begin
            n_tmo++;
            first_tmo = n;
         end
         if ((instr_rvalid_o || data_rvalid_o) && n != TMO) rv_early = 1'b1;
         if (tie && n == TMO) chk("tie_rvalid_wins", 64'(data_rvalid_o), 64'd1);
      end
      if (tie) chk("tie_no_pulse", 64'(n_tmo), 64'd0);
      else     chk("tmo_cycles_after_grant", 64'(first_tmo), 64'(TMO));
      chk({tag, "_no_early_rvalid"}, 64'(rv_early), 64'd0);
      tick(); idle_in('0); @(negedge clk); model_check({tag, "_after"});
      chk({tag, "_state_idle"}, 64'(dut.dbg.state), 64'(IDLE));
   endtask

   task automatic seq_reset_mid();
      tick(); set_in(0,1,8'h08,0,0,'0,'0,'0,0,0,'0); @(negedge clk); model_check("rm_req");
      tick(); set_in(0,1,8'h08,0,0,'0,'0,'0,1,0,'0); @(negedge clk); model_check("rm_gnt");
      chk("rm_instr_gnt", 64'(instr_gnt_o), 64'd1);
      tick(); idle_in('0); @(negedge clk); model_check("rm_wait");
      chk("rm_state_wait_rvalid", 64'(dut.dbg.state), 64'(WAIT_RVALID));
      tick(); idle_in('0); rst = 1'b1; @(negedge clk); model_check("rm_rst");
      for (int k = 0; k < 2; k++) begin
         tick(); idle_in(32'hCAFE_0000 + 32'(k)); mem_rvalid_i = 1'b1; @(negedge clk);
         model_check("rm_stray");
         chk("rm_no_irvalid", 64'(instr_rvalid_o), 64'd0);
         chk("rm_state_idle", 64'(dut.dbg.state), 64'(IDLE));
      end
      chk("rm_last_owner_data", 64'(dut.dbg.last_owner), 64'(DATA));
   endtask

   // ---------------- main test ----------------
   initial begin
      idle_in('0);
      rst = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("reset_ctrl", 64'(ctrl_now()), 64'd0);
      chk("reset_state", 64'(dut.dbg.state), 64'(IDLE));
      chk("reset_last_owner", 64'(dut.dbg.last_owner), 64'(DATA));
      tick(); idle_in('0); @(negedge clk); model_check("post_reset");

      fill_table();
      foreach (vecs[i]) begin
         tick();
         set_in(vecs[i].rst, vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe,
                vecs[i].dbe, vecs[i].daddr, vecs[i].dwdata, vecs[i].gnt, vecs[i].rv,
                vecs[i].rdata);
         @(negedge clk);
         chk($sformatf("vec%0d.ctrl", i), 64'(ctrl_now()), 64'(vecs[i].e_ctrl));
         chk($sformatf("vec%0d.irdata", i), 64'(instr_rdata_o), 64'(vecs[i].rdata));
         chk($sformatf("vec%0d.drdata", i), 64'(data_rdata_o), 64'(vecs[i].rdata));
         if (vecs[i].e_ctrl[1]) begin
            chk($sformatf("vec%0d.addr", i), 64'(mem_addr_o), 64'(vecs[i].e_addr));
            chk($sformatf("vec%0d.we", i), 64'(mem_we_o), 64'(vecs[i].e_we));
            chk($sformatf("vec%0d.be", i), 64'(mem_be_o), 64'(vecs[i].e_be));
            if (vecs[i].e_we)
               chk($sformatf("vec%0d.wdata", i), 64'(mem_wdata_o), 64'(vecs[i].e_wdata));
         end
      end

      seq_timeout(1'b0);
      seq_timeout(1'b1);
      seq_reset_mid();

      for (int c = 0; c < 3000; c++) begin
         tick();
         set_in($urandom_range(0, 249) == 0,
                1'($urandom_range(0, 1)), AW'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), BW'($urandom),
                AW'($urandom), DW'($urandom),
                1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, DW'($urandom));
         @(negedge clk);
         model_check("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog: actual=still running required=finished");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_WIDTH, 8, byte-address width.
- DATA_WIDTH, 32, word width.
- TIMEOUT, 64, maximum cycles waiting for mem_rvalid_i.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  ADDR_WIDTH  fetch address.
- instr_gnt_o  out  1  fetch request accepted.
- instr_rvalid_o  out  1  fetch data valid.
- instr_rdata_o  out  DATA_WIDTH  fetch data.
- data_req_i  in  1  load/store request.
- data_we_i  in  1  1 = store.
- data_be_i  in  DATA_WIDTH/8  byte enables.
- data_addr_i  in  ADDR_WIDTH  load/store address.
- data_wdata_i  in  DATA_WIDTH  store data.
- data_gnt_o  out  1  load/store accepted.
- data_rvalid_o  out  1  load data valid / store complete.
- data_rdata_o  out  DATA_WIDTH  load data.
- mem_req_o  out  1  request to shared memory.
- mem_we_o  out  1  write strobe.
- mem_be_o  out  DATA_WIDTH/8  byte enables.
- mem_addr_o  out  ADDR_WIDTH  address.
- mem_wdata_o  out  DATA_WIDTH  write data.
- mem_gnt_i  in  1  memory grant.
- mem_rvalid_i  in  1  memory response valid.
- mem_rdata_i  in  DATA_WIDTH  memory read data.
- timeout_o  out  1  one-cycle pulse on response timeout.

Function
REQ-003 The block SHALL share one req/gnt/rvalid memory port between two masters, with at most one transaction outstanding.
REQ-004 The FSM SHALL have states IDLE, WAIT_GNT and WAIT_RVALID.
- IDLE -> WAIT_GNT when any master request is high; owner is registered at the same edge.
- WAIT_GNT -> WAIT_RVALID on mem_gnt_i.
- WAIT_RVALID -> IDLE on mem_rvalid_i or on timeout.

REQ-005 Owner selection SHALL use round-robin.
- A single requester always wins.
- On a simultaneous request, the master not granted last wins.
- last_owner SHALL reset to DATA, so the first contention goes to instr.

REQ-006 mem_req_o SHALL equal (state == WAIT_GNT).
- mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o SHALL be muxed combinationally from the owner's live inputs.
- Instr transactions SHALL drive we = 0 and be = all-ones.

REQ-007 Grant routing SHALL be combinational: owner_gnt_o = mem_gnt_i & WAIT_GNT; the non-owner gnt SHALL stay 0.
REQ-008 Response routing SHALL be combinational: owner_rvalid_o = mem_rvalid_i & WAIT_RVALID; both rdata outputs SHALL mirror mem_rdata_i.
REQ-009 Minimum latency SHALL be one cycle from the master's req to mem_req_o; back-to-back transactions SHALL have one IDLE cycle between them.
REQ-010 A master dropping req in WAIT_GNT SHALL NOT abort the transaction; mem_req_o SHALL stay high until mem_gnt_i.
REQ-011 mem_rvalid_i SHALL be ignored in IDLE and WAIT_GNT.
REQ-012 The timeout counter SHALL behave as follows.
- Width: $clog2(TIMEOUT+1).
- Cleared on entry to WAIT_RVALID; increments each cycle in WAIT_RVALID.
- On reaching TIMEOUT without mem_rvalid_i: pulse timeout_o, return to IDLE, and emit no rvalid.
- If mem_rvalid_i and timeout occur in the same cycle, rvalid SHALL win and no pulse SHALL be emitted.

REQ-013 last_owner SHALL update on mem_gnt_i.

Reset
REQ-014 With rst high at a clock edge, the block SHALL set:
- state = IDLE, last_owner = DATA, counter = 0.
- All gnt, rvalid, mem_req_o and timeout_o outputs = 0.

REQ-015 Reset mid-transaction SHALL abandon the transaction silently; a later mem_rvalid_i SHALL be ignored.

Structure
REQ-016 The state enum, owner enum (INSTR, DATA) and default parameter values SHALL live in package mem_arb_pkg.
REQ-017 Owner selection SHALL be sub-module mem_arb_rr_pick (inputs: two reqs and last_owner; output: winner); all other logic SHALL reside in mem_port_arbiter.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Instr-only read of 0x04, memory grant delay 1 and rvalid delay 1 -> instr_gnt_o 1 cycle, instr_rvalid_o with rdata; data outputs stay 0.
- Both requesting every cycle from reset -> owner order instr, data, instr, data.
- Data store of 0xDEADBEEF to 0x70 with be = 4'b1111 -> mem_we_o = 1 and mem_wdata_o = 0xDEADBEEF while mem_req_o is high; data_rvalid_o follows.
- mem_rvalid_i never arrives, TIMEOUT = 64 -> timeout_o pulses 64 cycles after grant, FSM back in IDLE, no rvalid.
- rst asserted in WAIT_RVALID, then a stray mem_rvalid_i -> no rvalid output, state IDLE.
- Stray mem_rvalid_i in IDLE -> ignored.
